id_stage_sb: RTL and testbench

Parametrised decode stage with an integrated Tuse/Tnew scoreboard. It holds the IF/ID pipeline register, reads the general register file with write-through bypass, and computes the stall itself from per-register result-readiness counters instead of an external hazard comparator. It sits between fetch and execute and drives the D→E operand bus and the fetch-hold signal.

---
 rtl/id_sb_pkg.sv | 31 +++
 rtl/id_sb_grf.sv | 56 +++++
 rtl/id_stage_sb.sv | 133 +++++++++++++
 tb/tb_id_stage_sb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_sb_pkg.sv
// Shared constants, hazard record type and counter helper for the id_stage_sb decode stage.
package id_sb_pkg;

  localparam int TNEW_W_DEF = 2;
  localparam logic [TNEW_W_DEF-1:0] TUSE_NONE = {TNEW_W_DEF{1'b1}};
  localparam int REG_ZERO = 0;

  // Hazard fields are sized for the widest supported configuration; narrower
  // instances zero-extend into them, which keeps all-ones tuse as "never consumed".
  localparam int HZ_AW = 8;
  localparam int HZ_TW = 8;

  typedef struct packed {
    logic [HZ_AW-1:0] rs;
    logic [HZ_AW-1:0] rt;
    logic [HZ_TW-1:0] rs_tuse;
    logic [HZ_TW-1:0] rt_tuse;
    logic [HZ_AW-1:0] dst;
    logic             dst_we;
    logic [HZ_TW-1:0] tnew;
  } hazard_info_t;

  function automatic logic [HZ_TW-1:0] sat_dec(input logic [HZ_TW-1:0] c);
    if (c != {HZ_TW{1'b0}}) begin
      return c - HZ_TW'(1);
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/id_sb_grf.sv
// General register file: two combinational read ports with write-through bypass;
// register 0 reads as zero and ignores writes.
module id_sb_grf
  import id_sb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int REG_N = 32,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_r [REG_N];

  // Register array update; register 0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (waddr != AW'(REG_ZERO))) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Port A read with same-cycle write-through.
  always_comb begin
    if (raddr_a == AW'(REG_ZERO)) begin
      rdata_a = {XLEN{1'b0}};
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_r[raddr_a];
    end
  end

  // Port B read with same-cycle write-through.
  always_comb begin
    if (raddr_b == AW'(REG_ZERO)) begin
      rdata_b = {XLEN{1'b0}};
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_r[raddr_b];
    end
  end

endmodule

// File: rtl/id_stage_sb.sv
// Decode stage with IF/ID register, bypassed GRF read and a Tuse/Tnew scoreboard
// that produces its own stall. Define ID_SB_MD_EN to interlock mult/div issue on md_busy.
module id_stage_sb
  import id_sb_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int REG_N  = 32,
  parameter  int TNEW_W = TNEW_W_DEF,
  localparam int AW     = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic [XLEN-1:0]   f_pc,
  input  logic [31:0]       f_instr,
  output logic              d_ready,
  input  logic              flush,
  input  logic [AW-1:0]     dec_rs,
  input  logic [AW-1:0]     dec_rt,
  input  logic [TNEW_W-1:0] dec_rs_tuse,
  input  logic [TNEW_W-1:0] dec_rt_tuse,
  input  logic [AW-1:0]     dec_dst,
  input  logic              dec_dst_we,
  input  logic [TNEW_W-1:0] dec_tnew,
  input  logic              dec_md,
  input  logic              md_busy,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   d_pc,
  output logic [31:0]       d_instr,
  output logic [XLEN-1:0]   d_rs_data,
  output logic [XLEN-1:0]   d_rt_data,
  output logic              e_valid
);

  logic              v_r;
  logic [XLEN-1:0]   pc_r;
  logic [31:0]       instr_r;
  logic [TNEW_W-1:0] cnt_r [REG_N];

  hazard_info_t      hz_s;
  logic [HZ_TW-1:0]  rs_cnt_s;
  logic [HZ_TW-1:0]  rt_cnt_s;
  logic              haz_rs_s;
  logic              haz_rt_s;
  logic              haz_md_s;
  logic              stall_s;
  logic              issue_s;

`ifdef ID_SB_MD_EN
  assign haz_md_s = dec_md && md_busy;
`else
  logic md_unused_s;
  assign haz_md_s    = 1'b0;
  assign md_unused_s = dec_md ^ md_busy;
`endif

  // Pack the external decoder's fields into the shared hazard record.
  always_comb begin
    hz_s         = {$bits(hazard_info_t){1'b0}};
    hz_s.rs      = HZ_AW'(dec_rs);
    hz_s.rt      = HZ_AW'(dec_rt);
    hz_s.rs_tuse = HZ_TW'(dec_rs_tuse);
    hz_s.rt_tuse = HZ_TW'(dec_rt_tuse);
    hz_s.dst     = HZ_AW'(dec_dst);
    hz_s.dst_we  = dec_dst_we;
    hz_s.tnew    = HZ_TW'(dec_tnew);
  end

  // The producer already spent one cycle in E when the consumer is decoded, so
  // the post-decrement count is what must not exceed tuse. Flush beats stall.
  always_comb begin
    rs_cnt_s = sat_dec(HZ_TW'(cnt_r[dec_rs]));
    rt_cnt_s = sat_dec(HZ_TW'(cnt_r[dec_rt]));
    haz_rs_s = (hz_s.rs != HZ_AW'(REG_ZERO)) && (rs_cnt_s > hz_s.rs_tuse);
    haz_rt_s = (hz_s.rt != HZ_AW'(REG_ZERO)) && (rt_cnt_s > hz_s.rt_tuse);
    stall_s  = v_r && !flush && (haz_rs_s || haz_rt_s || haz_md_s);
    issue_s  = v_r && !stall_s && !flush;
  end

  assign d_ready = !stall_s;
  assign e_valid = issue_s;
  assign d_pc    = pc_r;
  assign d_instr = instr_r;

  // IF/ID pipeline register: accepts fetch whenever decode is not holding.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_r     <= 1'b0;
      pc_r    <= {XLEN{1'b0}};
      instr_r <= 32'h0000_0000;
    end else if (!stall_s) begin
      v_r     <= f_valid;
      pc_r    <= f_pc;
      instr_r <= f_instr;
    end
  end

  // Result-readiness counters: youngest issuing writer reloads, others count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        cnt_r[i] <= {TNEW_W{1'b0}};
      end
    end else begin
      cnt_r[0] <= {TNEW_W{1'b0}};
      for (int i = 1; i < REG_N; i++) begin
        if (issue_s && hz_s.dst_we && (hz_s.dst == HZ_AW'(i))) begin
          cnt_r[i] <= TNEW_W'(hz_s.tnew);
        end else if (cnt_r[i] != {TNEW_W{1'b0}}) begin
          cnt_r[i] <= cnt_r[i] - TNEW_W'(1);
        end
      end
    end
  end

  id_sb_grf #(
    .XLEN  (XLEN),
    .REG_N (REG_N)
  ) u_grf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (dec_rs),
    .raddr_b (dec_rt),
    .rdata_a (d_rs_data),
    .rdata_b (d_rt_data)
  );

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed self-checking bench for id_stage_sb: scoreboard stalls, register 0,
// write-through, flush during stall, mult/div interlock and reset mid-stall.
module tb_id_stage_sb;
  import id_sb_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_N  = 32;
  localparam int TNEW_W = 2;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_valid;
  logic [XLEN-1:0]   f_pc;
  logic [31:0]       f_instr;
  logic              d_ready;
  logic              flush;
  logic [AW-1:0]     dec_rs;
  logic [AW-1:0]     dec_rt;
  logic [TNEW_W-1:0] dec_rs_tuse;
  logic [TNEW_W-1:0] dec_rt_tuse;
  logic [AW-1:0]     dec_dst;
  logic              dec_dst_we;
  logic [TNEW_W-1:0] dec_tnew;
  logic              dec_md;
  logic              md_busy;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic [XLEN-1:0]   d_pc;
  logic [31:0]       d_instr;
  logic [XLEN-1:0]   d_rs_data;
  logic [XLEN-1:0]   d_rt_data;
  logic              e_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_stage_sb #(
    .XLEN   (XLEN),
    .REG_N  (REG_N),
    .TNEW_W (TNEW_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .f_valid     (f_valid),
    .f_pc        (f_pc),
    .f_instr     (f_instr),
    .d_ready     (d_ready),
    .flush       (flush),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_rs_tuse (dec_rs_tuse),
    .dec_rt_tuse (dec_rt_tuse),
    .dec_dst     (dec_dst),
    .dec_dst_we  (dec_dst_we),
    .dec_tnew    (dec_tnew),
    .dec_md      (dec_md),
    .md_busy     (md_busy),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .d_pc        (d_pc),
    .d_instr     (d_instr),
    .d_rs_data   (d_rs_data),
    .d_rt_data   (d_rt_data),
    .e_valid     (e_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    f_valid = v;
    f_pc    = pc;
    f_instr = ins;
  endtask

  task automatic set_dec(input logic [4:0] rs, input logic [1:0] rs_tu,
                         input logic [4:0] rt, input logic [1:0] rt_tu,
                         input logic [4:0] dst, input logic we, input logic [1:0] tn);
    dec_rs      = rs;
    dec_rs_tuse = rs_tu;
    dec_rt      = rt;
    dec_rt_tuse = rt_tu;
    dec_dst     = dst;
    dec_dst_we  = we;
    dec_tnew    = tn;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we   = we;
    wb_addr = a;
    wb_data = d;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later,
  // well before the next rising edge.
  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    dec_md  = 1'b0;
    md_busy = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    set_dec(5'd3, TUSE_NONE, 5'd4, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_e_valid", e_valid, 32'd0);
    chk("rst_d_ready", d_ready, 32'd1);
    chk("rst_d_pc", d_pc, 32'h0);
    chk("rst_d_instr", d_instr, 32'h0);
    chk("rst_rs_data", d_rs_data, 32'h0);
    chk("rst_rt_data", d_rt_data, 32'h0);

    // Back-to-back: writer $8 tnew=2, then reader with rs_tuse=0.
    @(negedge clk); reset = 1'b0;
    fetch(1'b1, 32'h100, 32'hA);
    set_dec(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    #1; chk("empty_no_issue", e_valid, 32'd0);
    @(negedge clk);
    fetch(1'b1, 32'h104, 32'hB);
    set_dec(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd8, 1'b1, 2'd2);
    #1; chk("b2b_writer_issue", e_valid, 32'd1);
    chk("b2b_writer_pc", d_pc, 32'h100);
    chk("b2b_writer_instr", d_instr, 32'hA);
    @(negedge clk);
    fetch(1'b1, 32'h108, 32'hC);
    set_dec(5'd8, 2'd0, 5'd0, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    #1; chk("b2b_stall_evalid", e_valid, 32'd0);
    chk("b2b_stall_dready", d_ready, 32'd0);
    chk("b2b_stall_pc", d_pc, 32'h104);
    @(negedge clk);
    #1; chk("b2b_release_evalid", e_valid, 32'd1);
    chk("b2b_release_dready", d_ready, 32'd1);
    chk("b2b_release_pc", d_pc, 32'h104);

    // Tuse satisfied: writer $9 tnew=1, reader with rt_tuse=1.
    @(negedge clk);
    fetch(1'b1, 32'h10C, 32'hD);
    set_dec(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd9, 1'b1, 2'd1);
    #1; chk("tuse_writer_pc", d_pc, 32'h108);
    chk("tuse_writer_issue", e_valid, 32'd1);
    @(negedge clk);
    fetch(1'b1, 32'h110, 32'hE);
    set_dec(5'd0, TUSE_NONE, 5'd9, 2'd1, 5'd0, 1'b0, 2'd0);
    #1; chk("tuse_ok_evalid", e_valid, 32'd1);
    chk("tuse_ok_dready", d_ready, 32'd1);

    // Register 0: writer of $0 tnew=3, reader of $0 tuse=0; write DEADBEEF to $0.
    @(negedge clk);
    fetch(1'b1, 32'h114, 32'hF);
    set_dec(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 1'b1, 2'd3);
    wb(1'b1, 5'd0, 32'hDEADBEEF);
    #1; chk("r0_writer_issue", e_valid, 32'd1);
    chk("r0_writer_pc", d_pc, 32'h110);
    @(negedge clk);
    fetch(1'b1, 32'h118, 32'h10);
    set_dec(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    #1; chk("r0_no_stall", e_valid, 32'd1);
    chk("r0_rs_read", d_rs_data, 32'h0);
    chk("r0_rt_read", d_rt_data, 32'h0);

    // Write-through on both ports, and a stored value read back.
    @(negedge clk);
    fetch(1'b1, 32'h11C, 32'h11);
    wb(1'b1, 5'd5, 32'h12345678);
    set_dec(5'd5, TUSE_NONE, 5'd6, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    #1; chk("wt_rs", d_rs_data, 32'h12345678);
    chk("wt_rt_untouched", d_rt_data, 32'h0);
    chk("wt_pc", d_pc, 32'h118);
    @(negedge clk);
    fetch(1'b1, 32'h120, 32'h12);
    wb(1'b1, 5'd6, 32'hCAFEF00D);
    set_dec(5'd5, TUSE_NONE, 5'd6, TUSE_NONE, 5'd10, 1'b1, 2'd3);
    #1; chk("grf_rs_stored", d_rs_data, 32'h12345678);
    chk("wt_rt", d_rt_data, 32'hCAFEF00D);
    chk("writer10_issue", e_valid, 32'd1);

    // Flush during stall: reader of $10 stalls, then flush with a new fetch.
    @(negedge clk);
    fetch(1'b1, 32'h124, 32'h13);
    wb(1'b0, 5'd0, 32'h0);
    set_dec(5'd10, 2'd0, 5'd0, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    #1; chk("fl_pre_stall_evalid", e_valid, 32'd0);
    chk("fl_pre_stall_dready", d_ready, 32'd0);
    chk("fl_pre_stall_pc", d_pc, 32'h120);
    @(negedge clk);
    fetch(1'b1, 32'h200, 32'hF00);
    flush = 1'b1;
    set_dec(5'd10, 2'd0, 5'd0, TUSE_NONE, 5'd11, 1'b1, 2'd3);
    #1; chk("fl_evalid", e_valid, 32'd0);
    chk("fl_dready", d_ready, 32'd1);
    chk("fl_held_pc", d_pc, 32'h120);
    @(negedge clk);
    flush = 1'b0;
    fetch(1'b0, 32'h204, 32'h14);
    set_dec(5'd11, 2'd0, 5'd10, 2'd0, 5'd0, 1'b0, 2'd0);
    #1; chk("fl_new_pc", d_pc, 32'h200);
    chk("fl_new_instr", d_instr, 32'hF00);
    chk("fl_sb_clean", e_valid, 32'd1);
    @(negedge clk);
    fetch(1'b1, 32'h208, 32'h15);
    set_dec(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    #1; chk("bubble_evalid", e_valid, 32'd0);
    chk("bubble_dready", d_ready, 32'd1);

    // Mult/div interlock while md_busy is high for three cycles.
    @(negedge clk);
    fetch(1'b1, 32'h20C, 32'h16);
    dec_md  = 1'b1;
    md_busy = 1'b1;
    #1; chk("md_pc", d_pc, 32'h208);
`ifdef ID_SB_MD_EN
    chk("md_stall_0", e_valid, 32'd0);
    @(negedge clk);
    #1; chk("md_stall_1", e_valid, 32'd0);
    chk("md_stall_1_pc", d_pc, 32'h208);
    @(negedge clk);
    #1; chk("md_stall_2", e_valid, 32'd0);
    @(negedge clk);
    md_busy = 1'b0;
    #1; chk("md_issue", e_valid, 32'd1);
    chk("md_issue_pc", d_pc, 32'h208);
`else
    chk("md_ignored_issue", e_valid, 32'd1);
    chk("md_ignored_dready", d_ready, 32'd1);
`endif

    // Reset while a reader of $12 is stalled behind a tnew=3 writer.
    @(negedge clk);
    dec_md  = 1'b0;
    md_busy = 1'b0;
    fetch(1'b1, 32'h300, 32'h17);
    set_dec(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd12, 1'b1, 2'd3);
    #1; chk("rst_writer_pc", d_pc, 32'h20C);
    chk("rst_writer_issue", e_valid, 32'd1);
    @(negedge clk);
    fetch(1'b1, 32'h304, 32'h18);
    set_dec(5'd12, 2'd0, 5'd0, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    #1; chk("rst_pre_stall", e_valid, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_dec(5'd12, 2'd0, 5'd5, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    #1; chk("rst_mid_evalid", e_valid, 32'd0);
    chk("rst_mid_pc", d_pc, 32'h0);
    chk("rst_mid_dready", d_ready, 32'd1);
    chk("rst_mid_grf", d_rt_data, 32'h0);
    @(negedge clk);
    fetch(1'b0, 32'h0, 32'h0);
    #1; chk("rst_cnt_clear_pc", d_pc, 32'h304);
    chk("rst_cnt_clear_issue", e_valid, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
